// File: rtl/moddiv_pkg.sv
// Shared constants and FSM encoding for the modular-division datapath blocks.
package moddiv_pkg;

  localparam int unsigned NWORDS = 16;
  localparam int unsigned W      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StUnload
  } word_io_state_e;

endpackage

// File: rtl/minv_word_io.sv
// Word-serial load/unload of the 256-bit U/T register plus single-bit right-shift arbitration.
// Only drives the register's control lines; the register and its input mux live elsewhere.
module minv_word_io #(
  parameter int unsigned NWORDS = moddiv_pkg::NWORDS,
  parameter int unsigned W      = moddiv_pkg::W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start,
  input  logic         unload_start,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  input  logic         shr_req,
  output logic         shr_ack,
  output logic         busy,
  output logic         done,
  output logic         reg_we,
  output logic         reg_sel_cyc,
  output logic         reg_sel_rs,
  output logic [W-1:0] reg_din,
  input  logic [W-1:0] reg_low
);

  localparam int unsigned CntW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NWORDS - 1);

  moddiv_pkg::word_io_state_e state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic                       done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= moddiv_pkg::StIdle;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = '0;
    shr_ack     = 1'b0;
    reg_we      = 1'b0;
    reg_sel_cyc = 1'b0;
    reg_sel_rs  = 1'b0;
    reg_din     = '0;

    unique case (state_q)
      moddiv_pkg::StIdle: begin
        // Start requests take priority over a pending shift request.
        if (load_start) begin
          state_d = moddiv_pkg::StLoad;
          cnt_d   = '0;
        end else if (unload_start) begin
          state_d = moddiv_pkg::StUnload;
          cnt_d   = '0;
        end else if (shr_req) begin
          shr_ack    = 1'b1;
          reg_we     = 1'b1;
          reg_sel_rs = 1'b1;
        end
      end
      moddiv_pkg::StLoad: begin
        in_ready = 1'b1;
        if (in_valid) begin
          reg_we  = 1'b1;
          reg_din = in_data;
          if (cnt_q == CntLast) begin
            state_d = moddiv_pkg::StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      moddiv_pkg::StUnload: begin
        out_valid = 1'b1;
        out_data  = reg_low;
        // A full 16-word rotation restores the register, so unload is non-destructive.
        if (out_ready) begin
          reg_we      = 1'b1;
          reg_sel_cyc = 1'b1;
          if (cnt_q == CntLast) begin
            state_d = moddiv_pkg::StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = moddiv_pkg::StIdle;
    endcase
  end

  assign busy = (state_q != moddiv_pkg::StIdle);
  assign done = done_q;

endmodule

// File: tb/tb_minv_word_io.sv
// Directed bench for minv_word_io with a behavioural 256-bit U/T register model.
module tb_minv_word_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, unload_start, in_valid, out_ready, shr_req;
  logic [15:0] in_data;
  logic        in_ready, out_valid, shr_ack, busy, done;
  logic        reg_we, reg_sel_cyc, reg_sel_rs;
  logic [15:0] out_data, reg_din, reg_low;

  logic [255:0] model_q;
  logic [255:0] exp_reg;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  minv_word_io dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .unload_start (unload_start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .shr_req      (shr_req),
    .shr_ack      (shr_ack),
    .busy         (busy),
    .done         (done),
    .reg_we       (reg_we),
    .reg_sel_cyc  (reg_sel_cyc),
    .reg_sel_rs   (reg_sel_rs),
    .reg_din      (reg_din),
    .reg_low      (reg_low)
  );

  // Register model: load shifts a word in at the top, cyc rotates by a word, rs shifts by one bit.
  always_ff @(posedge clk) begin
    if (reg_we) begin
      if (reg_sel_rs)       model_q <= {1'b0, model_q[255:1]};
      else if (reg_sel_cyc) model_q <= {model_q[15:0], model_q[255:16]};
      else                  model_q <= {reg_din, model_q[255:16]};
    end
  end
  assign reg_low = model_q[15:0];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".out_data"}, out_data, 0);
    check({tag, ".shr_ack"}, shr_ack, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".reg_we"}, reg_we, 0);
    check({tag, ".reg_sel_cyc"}, reg_sel_cyc, 0);
    check({tag, ".reg_sel_rs"}, reg_sel_rs, 0);
    check({tag, ".reg_din"}, reg_din, 0);
  endtask

  // Full load of words base+0..base+15 with in_valid held high; shr_req held high throughout.
  task automatic do_load(input logic [15:0] base, input string tag);
    load_start = 1'b1;
    shr_req    = 1'b1;
    #1;
    check({tag, ".start_no_ack"}, shr_ack, 0);
    step();
    load_start   = 1'b0;
    unload_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = base + 16'(i);
      #1;
      check({tag, ".in_ready"}, in_ready, 1);
      check({tag, ".reg_we"}, reg_we, 1);
      check({tag, ".cyc"}, reg_sel_cyc, 0);
      check({tag, ".rs"}, reg_sel_rs, 0);
      check({tag, ".shr_ack"}, shr_ack, 0);
      check({tag, ".reg_din"}, reg_din, base + 16'(i));
      check({tag, ".done_early"}, done, 0);
      step();
    end
    in_valid = 1'b0;
    shr_req  = 1'b0;
    in_data  = '0;
    #1;
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_after"}, busy, 0);
    step();
    check({tag, ".done_once"}, done, 0);
    for (int i = 0; i < 16; i++) exp_reg[16*i +: 16] = base + 16'(i);
    check({tag, ".reg"}, model_q, exp_reg);
  endtask

  initial begin
    int idx;
    int k;
    logic rdy;

    rst_n        = 1'b0;
    load_start   = 1'b0;
    unload_start = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;
    shr_req      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Both starts high: load must win; shr_req ignored while loading.
    unload_start = 1'b1;
    do_load(16'h0001, "load1");

    do_load(16'hA000, "loadA");

    // Unload with out_ready held high.
    unload_start = 1'b1;
    step();
    unload_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b1;
      #1;
      check("unl.out_valid", out_valid, 1);
      check("unl.out_data", out_data, 16'hA000 + 16'(i));
      check("unl.reg_we", reg_we, 1);
      check("unl.cyc", reg_sel_cyc, 1);
      check("unl.rs", reg_sel_rs, 0);
      step();
    end
    out_ready = 1'b0;
    check("unl.done", done, 1);
    check("unl.busy", busy, 0);
    check("unl.out_valid_off", out_valid, 0);
    check("unl.reg_restored", model_q, exp_reg);
    step();

    // Unload with out_ready pattern 1,0,0 repeating.
    unload_start = 1'b1;
    step();
    unload_start = 1'b0;
    idx = 0;
    k   = 0;
    while (idx < 16 && k < 80) begin
      rdy       = (k % 3 == 0);
      out_ready = rdy;
      #1;
      check("tgl.out_valid", out_valid, 1);
      check("tgl.out_data", out_data, 16'hA000 + 16'(idx));
      check("tgl.reg_we", reg_we, rdy);
      if (rdy) idx++;
      k++;
      step();
    end
    out_ready = 1'b0;
    check("tgl.words", idx, 16);
    check("tgl.done", done, 1);
    check("tgl.reg_restored", model_q, exp_reg);
    step();

    // Three consecutive shift requests in IDLE.
    for (int i = 0; i < 3; i++) begin
      shr_req = 1'b1;
      #1;
      check("shr.ack", shr_ack, 1);
      check("shr.reg_we", reg_we, 1);
      check("shr.rs", reg_sel_rs, 1);
      check("shr.cyc", reg_sel_cyc, 0);
      step();
    end
    shr_req = 1'b0;
    #1;
    check("shr.ack_off", shr_ack, 0);
    check("shr.reg_we_off", reg_we, 0);
    check("shr.reg", model_q, exp_reg >> 3);

    // Reset after the 7th word of a load aborts it.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h5500 + 16'(i);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
    rst_n    = 1'b0;
    step();
    check_all_zero("abort");
    rst_n = 1'b1;
    step();
    do_load(16'h0100, "reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/minv_word_io.md
MINV_WORD_IO -- requirements
Module: minv_word_io

Interface
REQ-001 Parameter NWORDS, default 16: number of 16-bit words per 256-bit operand.
REQ-002 Parameter W, default 16: word width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 load_start  input  1  request to load one operand from the word bus.
REQ-006 unload_start  input  1  request to read the operand out, non-destructively.
REQ-007 in_valid  input  1  an input word is present.
REQ-008 in_data  input  W  input word, least-significant word first.
REQ-009 in_ready  output  1  the block accepts in_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  W  output word, least-significant word first.
REQ-012 out_ready  input  1  the consumer accepts out_data this cycle.
REQ-013 shr_req  input  1  core requests one right shift by 1 bit.
REQ-014 shr_ack  output  1  shr_req is honoured this cycle.
REQ-015 busy  output  1  the block is in LOAD or UNLOAD.
REQ-016 done  output  1  one-cycle pulse on completion of a load or an unload.
REQ-017 reg_we, reg_sel_cyc, reg_sel_rs  output  1 each  control lines to the 256-bit U/T register.
REQ-018 reg_din  output  W  word written into the register.
REQ-019 reg_low  input  W  bits [15:0] of the register output.

Function
REQ-020 FSM states: IDLE, LOAD, UNLOAD. Word counter cnt, width clog2(NWORDS).
REQ-021 In IDLE, load_start takes the FSM to LOAD with cnt=0. If load_start is low, unload_start takes it to UNLOAD with cnt=0. When both are high, load_start wins.
REQ-022 In LOAD: in_ready=1. On each in_valid&&in_ready, the block drives reg_we=1, reg_sel_cyc=0, reg_sel_rs=0, reg_din=in_data, in the same cycle, and cnt increments.
REQ-023 In UNLOAD: out_valid=1 and out_data=reg_low, combinational. On each out_valid&&out_ready, the block drives reg_we=1, reg_sel_cyc=1, reg_sel_rs=0, which rotates the register by 16 bits; cnt increments.
REQ-024 After transfer NWORDS-1 is accepted, the next state is IDLE and done=1 for exactly the following cycle. After an unload the register content equals its content before the unload.
REQ-025 Stalls: if in_valid=0 (LOAD) or out_ready=0 (UNLOAD), reg_we=0 and cnt holds. No timeout applies.
REQ-026 shr_ack=1 only in IDLE with shr_req=1 and both start inputs low. On shr_ack, the block drives reg_we=1, reg_sel_rs=1, reg_sel_cyc=0.
REQ-027 shr_req is ignored when not in IDLE, and when any start input is high.
REQ-028 load_start and unload_start are ignored outside IDLE.
REQ-029 Latency: a start input is registered, so in_ready or out_valid rises on the cycle after the start cycle. Minimum load or unload time is NWORDS+1 cycles from start to done.
REQ-030 cnt wraps from NWORDS-1 to 0 on the final transfer.
REQ-031 In every cycle not covered by REQ-022, REQ-023 and REQ-026, reg_we=0, reg_sel_cyc=0, reg_sel_rs=0, and reg_din=0.

Reset
REQ-032 While rst_n=0 at a clock edge, the next state is IDLE, cnt=0 and done=0.
REQ-033 After reset, every output is 0.
REQ-034 Reset during LOAD or UNLOAD aborts the transfer. Register content is then undefined for an aborted load and partially rotated for an aborted unload; no restore is attempted.

Structure
REQ-035 The FSM state encoding and the constants NWORDS=16 and W=16 live in the shared moddiv package.
REQ-036 The block is a single module with no sub-modules. It instantiates neither the register nor its mux; it only drives their control lines.

Verification
REQ-037 Load words 0x0001..0x0010 with in_valid held high -> 16 reg_we pulses with reg_sel_cyc=0; done one cycle after the 16th transfer; busy low the following cycle.
REQ-038 Unload with a register model preloaded with words 0xA000+i -> out_data sequence 0xA000..0xA00F; register model content equal to the original afterwards.
REQ-039 Unload with out_ready toggling 1,0,0,1,... -> no word lost or duplicated; reg_we asserted only on handshake cycles.
REQ-040 load_start and unload_start both high in IDLE -> FSM enters LOAD; shr_req high during LOAD -> shr_ack=0 and reg_sel_rs=0 throughout.
REQ-041 shr_req held high for 3 IDLE cycles -> 3 cycles with shr_ack=1, reg_we=1, reg_sel_rs=1.
REQ-042 rst_n driven low after the 7th word of a load -> all outputs 0 on the next cycle; a new load_start then accepts 16 fresh words.
